wb_stage_rf: RTL and testbench

- Parametrised successor of the write-back stage.
- Takes one retiring instruction per cycle over a valid/ready handshake and selects the result (ALU, load, PC+4).
- Aligns and sign- or zero-extends load data, then writes the integer register file it owns.
- Provides N bypassed read ports to decode, plus a forwarding tap and a retired-instruction counter.

---
 rtl/constants_pkg.sv | 38 +++
 rtl/regfile_mp.sv | 46 ++++
 rtl/wb_stage_rf.sv | 76 +++++++
 tb/tb_wb_stage_rf.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/constants_pkg.sv
// Shared write-back constants: result-select encoding, RV32I load funct3 codes
// and the load align/extend helper used by the write-back stage.
package constants_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_LOAD = 2'd1,
      WB_PC4  = 2'd2,
      WB_NONE = 2'd3
   } wb_sel_e;

   localparam logic [2:0] LOAD_F3_LB  = 3'b000;
   localparam logic [2:0] LOAD_F3_LH  = 3'b001;
   localparam logic [2:0] LOAD_F3_LW  = 3'b010;
   localparam logic [2:0] LOAD_F3_LBU = 3'b100;
   localparam logic [2:0] LOAD_F3_LHU = 3'b101;

   // Picks the addressed byte/half of an aligned word and extends it to XLEN.
   // Unknown funct3 codes fall back to the full word.
   function automatic logic [XLEN-1:0] load_extend(input logic [2:0]      funct3,
                                                   input logic [1:0]      addr_lo,
                                                   input logic [XLEN-1:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{addr_lo, 3'b000} +: 8];
      h = addr_lo[1] ? word[31:16] : word[15:0];
      case (funct3)
         LOAD_F3_LB:  load_extend = {{24{b[7]}}, b};
         LOAD_F3_LBU: load_extend = {24'd0, b};
         LOAD_F3_LH:  load_extend = {{16{h[15]}}, h};
         LOAD_F3_LHU: load_extend = {16'd0, h};
         default:     load_extend = word;
      endcase
   endfunction

endpackage

// File: rtl/regfile_mp.sv
// Integer register file with one write port and NUM_RD_PORTS combinational
// read ports; x0 reads as zero and optional same-cycle write bypass.
module regfile_mp
   import constants_pkg::*;
#(
   parameter int NUM_REGS     = 32,
   parameter int NUM_RD_PORTS = 2,
   parameter int BYPASS_EN    = 1,
   localparam int AW          = $clog2(NUM_REGS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         we,
   input  logic [AW-1:0]                waddr,
   input  logic [XLEN-1:0]              wdata,
   input  logic [NUM_RD_PORTS*AW-1:0]   raddr,
   output logic [NUM_RD_PORTS*XLEN-1:0] rdata
);

   logic [XLEN-1:0] regs [NUM_REGS];

   // NOTE: the array is cleared by reset because software relies on a
   // zeroed register file; this keeps it out of a plain RAM macro.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (we && (waddr != '0)) begin
         regs[waddr] <= wdata;
      end
   end

   for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
      logic [AW-1:0] a;
      assign a = raddr[p*AW +: AW];

      always_comb begin
         rdata[p*XLEN +: XLEN] = '0;
         if (a != '0) begin
            rdata[p*XLEN +: XLEN] = regs[a];
            if ((BYPASS_EN != 0) && we && (a == waddr))
               rdata[p*XLEN +: XLEN] = wdata;
         end
      end
   end

endmodule

// File: rtl/wb_stage_rf.sv
// Write-back stage: accepts one retiring instruction per cycle, selects and
// extends the result, writes the owned register file and counts retirements.
module wb_stage_rf
   import constants_pkg::*;
#(
   parameter int NUM_REGS     = 32,
   parameter int NUM_RD_PORTS = 2,
   parameter int BYPASS_EN    = 1,
   parameter int CNT_W        = 64,
   localparam int AW          = $clog2(NUM_REGS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wb_valid_i,
   output logic                         wb_ready_o,
   input  logic                         stall_i,
   input  logic                         wb_we_i,
   input  logic [AW-1:0]                wb_rd_i,
   input  logic [1:0]                   wb_sel_i,
   input  logic [XLEN-1:0]              alu_result_i,
   input  logic [XLEN-1:0]              mem_rdata_i,
   input  logic [XLEN-1:0]              pc_plus4_i,
   input  logic [2:0]                   load_funct3_i,
   input  logic [1:0]                   load_addr_lo_i,
   input  logic [NUM_RD_PORTS*AW-1:0]   rd_addr_i,
   output logic [NUM_RD_PORTS*XLEN-1:0] rd_data_o,
   output logic                         fwd_valid_o,
   output logic [AW-1:0]                fwd_rd_o,
   output logic [XLEN-1:0]              fwd_data_o,
   output logic [CNT_W-1:0]             instret_o
);

   wb_sel_e         sel;
   logic            accept;
   logic            commit;
   logic [XLEN-1:0] result;

   assign sel        = wb_sel_e'(wb_sel_i);
   assign wb_ready_o = !stall_i && !rst;
   assign accept     = wb_valid_i && wb_ready_o;
   // The reserved select retires but never writes.
   assign commit     = accept && wb_we_i && (wb_rd_i != '0) && (sel != WB_NONE);

   always_comb begin
      result = alu_result_i;
      case (sel)
         WB_LOAD: result = load_extend(load_funct3_i, load_addr_lo_i, mem_rdata_i);
         WB_PC4:  result = pc_plus4_i;
         default: result = alu_result_i;
      endcase
   end

   assign fwd_valid_o = commit;
   assign fwd_rd_o    = wb_rd_i;
   assign fwd_data_o  = result;

   always_ff @(posedge clk) begin
      if (rst)         instret_o <= '0;
      else if (accept) instret_o <= instret_o + CNT_W'(1);
   end

   regfile_mp #(
      .NUM_REGS     (NUM_REGS),
      .NUM_RD_PORTS (NUM_RD_PORTS),
      .BYPASS_EN    (BYPASS_EN)
   ) u_rf (
      .clk   (clk),
      .rst   (rst),
      .we    (commit),
      .waddr (wb_rd_i),
      .wdata (result),
      .raddr (rd_addr_i),
      .rdata (rd_data_o)
   );

endmodule

// File: tb/tb_wb_stage_rf.sv
// Directed bench for wb_stage_rf: a bypassing and a non-bypassing instance
// (8-bit counters) share all stimulus and are checked against hand values.
module tb_wb_stage_rf;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_valid_i, stall_i, wb_we_i;
   logic [4:0]  wb_rd_i;
   logic [1:0]  wb_sel_i;
   logic [31:0] alu_result_i, mem_rdata_i, pc_plus4_i;
   logic [2:0]  load_funct3_i;
   logic [1:0]  load_addr_lo_i;
   logic [9:0]  rd_addr_i;

   logic        ready_b, ready_n, fv_b, fv_n;
   logic [4:0]  frd_b, frd_n;
   logic [31:0] fdata_b, fdata_n;
   logic [63:0] rdata_b, rdata_n;
   logic [7:0]  inst_b, inst_n;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   wb_stage_rf #(.NUM_REGS(32), .NUM_RD_PORTS(2), .BYPASS_EN(1), .CNT_W(8)) dut_b (
      .clk(clk), .rst(rst), .wb_valid_i(wb_valid_i), .wb_ready_o(ready_b),
      .stall_i(stall_i), .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_sel_i(wb_sel_i),
      .alu_result_i(alu_result_i), .mem_rdata_i(mem_rdata_i), .pc_plus4_i(pc_plus4_i),
      .load_funct3_i(load_funct3_i), .load_addr_lo_i(load_addr_lo_i),
      .rd_addr_i(rd_addr_i), .rd_data_o(rdata_b), .fwd_valid_o(fv_b),
      .fwd_rd_o(frd_b), .fwd_data_o(fdata_b), .instret_o(inst_b));

   wb_stage_rf #(.NUM_REGS(32), .NUM_RD_PORTS(2), .BYPASS_EN(0), .CNT_W(8)) dut_n (
      .clk(clk), .rst(rst), .wb_valid_i(wb_valid_i), .wb_ready_o(ready_n),
      .stall_i(stall_i), .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_sel_i(wb_sel_i),
      .alu_result_i(alu_result_i), .mem_rdata_i(mem_rdata_i), .pc_plus4_i(pc_plus4_i),
      .load_funct3_i(load_funct3_i), .load_addr_lo_i(load_addr_lo_i),
      .rd_addr_i(rd_addr_i), .rd_data_o(rdata_n), .fwd_valid_o(fv_n),
      .fwd_rd_o(frd_n), .fwd_data_o(fdata_n), .instret_o(inst_n));

   // A writing instruction must never use the reserved select.
   always @(posedge clk)
      if (wb_valid_i && wb_we_i)
         assert (wb_sel_i != 2'd3) else $error("reserved wb_sel with we");

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic [4:0] rd, input logic [1:0] sel,
                        input logic [31:0] alu, input logic [2:0] f3, input logic [1:0] lo);
      wb_valid_i     = 1'b1;
      wb_we_i        = we;
      wb_rd_i        = rd;
      wb_sel_i       = sel;
      alu_result_i   = alu;
      load_funct3_i  = f3;
      load_addr_lo_i = lo;
      #1;
   endtask

   task automatic idle();
      wb_valid_i = 1'b0;
      wb_we_i    = 1'b0;
      #1;
   endtask

   task automatic read(input logic [4:0] a0, input logic [4:0] a1);
      rd_addr_i = {a1, a0};
      #1;
   endtask

   initial begin
      rst = 1'b1; stall_i = 1'b0; wb_valid_i = 1'b0; wb_we_i = 1'b0;
      wb_rd_i = '0; wb_sel_i = '0; alu_result_i = '0; pc_plus4_i = '0;
      mem_rdata_i = 32'h80F0_7F01; load_funct3_i = '0; load_addr_lo_i = '0;
      rd_addr_i = '0;

      // Reset: ready and forwarding held low even with a valid write present.
      step();
      drive(1'b1, 5'd5, 2'd0, 32'h5555_5555, 3'b010, 2'd0);
      check("rst_ready", ready_b, 0);
      check("rst_fwd_valid", fv_b, 0);
      step();
      rst = 1'b0;
      idle();
      read(5'd5, 5'd0);
      check("rst_x5", rdata_b[31:0], 0);
      check("rst_instret", inst_b, 0);
      check("ready_after_rst", ready_b, 1);

      // ALU write of x5.
      drive(1'b1, 5'd5, 2'd0, 32'hDEAD_BEEF, 3'b010, 2'd0);
      check("alu_fwd_valid", fv_b, 1);
      check("alu_fwd_rd", frd_b, 5);
      check("alu_fwd_data", fdata_b, 32'hDEAD_BEEF);
      step();
      idle();
      check("alu_x5", rdata_b[31:0], 32'hDEAD_BEEF);
      check("alu_x5_nb", rdata_n[31:0], 32'hDEAD_BEEF);
      check("alu_instret", inst_b, 1);

      // Loads from word 0x80F07F01 into x1..x4 and x6.
      drive(1'b1, 5'd1, 2'd1, 32'h0, 3'b000, 2'd3);
      check("lb_lane3", fdata_b, 32'hFFFF_FF80);
      step();
      drive(1'b1, 5'd2, 2'd1, 32'h0, 3'b100, 2'd2);
      check("lbu_lane2", fdata_b, 32'h0000_00F0);
      step();
      drive(1'b1, 5'd3, 2'd1, 32'h0, 3'b001, 2'd2);
      check("lh_lane2", fdata_b, 32'hFFFF_80F0);
      step();
      drive(1'b1, 5'd4, 2'd1, 32'h0, 3'b101, 2'd0);
      check("lhu_lane0", fdata_b, 32'h0000_7F01);
      step();
      drive(1'b1, 5'd6, 2'd1, 32'h0, 3'b010, 2'd3);
      check("lw_off3", fdata_b, 32'h80F0_7F01);
      step();
      idle();
      read(5'd1, 5'd2);
      check("rb_x1", rdata_b[31:0], 32'hFFFF_FF80);
      check("rb_x2", rdata_b[63:32], 32'h0000_00F0);
      read(5'd3, 5'd4);
      check("rb_x3", rdata_b[31:0], 32'hFFFF_80F0);
      check("rb_x4", rdata_b[63:32], 32'h0000_7F01);
      read(5'd6, 5'd0);
      check("rb_x6", rdata_b[31:0], 32'h80F0_7F01);
      check("rb_x0_port1", rdata_b[63:32], 0);
      check("load_instret", inst_b, 6);

      // Same-cycle read of x7 while it is being written.
      drive(1'b1, 5'd7, 2'd0, 32'h1111_1111, 3'b010, 2'd0);
      step();
      drive(1'b1, 5'd7, 2'd0, 32'h1234_5678, 3'b010, 2'd0);
      read(5'd7, 5'd7);
      check("byp_port1", rdata_b[63:32], 32'h1234_5678);
      check("byp_port0_same", rdata_b[31:0], 32'h1234_5678);
      check("nobyp_port1_old", rdata_n[63:32], 32'h1111_1111);
      check("nobyp_port0_old", rdata_n[31:0], 32'h1111_1111);
      step();
      idle();
      check("nobyp_port1_new", rdata_n[63:32], 32'h1234_5678);
      check("byp_port1_new", rdata_b[63:32], 32'h1234_5678);
      check("byp_instret", inst_b, 8);

      // x0 write is dropped but retires.
      drive(1'b1, 5'd0, 2'd0, 32'hFFFF_FFFF, 3'b010, 2'd0);
      read(5'd0, 5'd0);
      check("x0_fwd_valid", fv_b, 0);
      check("x0_read_same", rdata_b[31:0], 0);
      step();
      idle();
      check("x0_read_after", rdata_b[63:32], 0);
      check("x0_read_after_nb", rdata_n[31:0], 0);
      check("x0_instret", inst_b, 9);

      // Reserved select without write still retires; PC+4 select writes x10.
      drive(1'b0, 5'd8, 2'd3, 32'hCAFE_0000, 3'b010, 2'd0);
      check("none_fwd_valid", fv_b, 0);
      step();
      pc_plus4_i = 32'h0000_1004;
      drive(1'b1, 5'd10, 2'd2, 32'hBAD0_BAD0, 3'b010, 2'd0);
      check("pc4_fwd_data", fdata_b, 32'h0000_1004);
      step();
      idle();
      read(5'd10, 5'd8);
      check("pc4_x10", rdata_b[31:0], 32'h0000_1004);
      check("none_x8", rdata_b[63:32], 0);
      check("pc4_instret", inst_b, 11);

      // Stall with a valid write of x9 for three cycles.
      stall_i = 1'b1;
      drive(1'b1, 5'd9, 2'd0, 32'h0000_0001, 3'b010, 2'd0);
      read(5'd9, 5'd9);
      check("stall_ready", ready_b, 0);
      check("stall_fwd_valid", fv_b, 0);
      for (int i = 0; i < 3; i++) step();
      check("stall_x9", rdata_b[31:0], 0);
      check("stall_instret", inst_b, 11);
      stall_i = 1'b0;
      #1;
      check("release_fwd_valid", fv_b, 1);
      step();
      idle();
      check("release_x9", rdata_b[31:0], 1);
      check("release_instret", inst_b, 12);

      // Counter wrap: bring it to 255, then one more accept.
      drive(1'b0, 5'd0, 2'd0, 32'h0, 3'b010, 2'd0);
      for (int i = 0; i < 243; i++) step();
      idle();
      check("instret_max", inst_b, 8'd255);
      drive(1'b0, 5'd0, 2'd0, 32'h0, 3'b010, 2'd0);
      step();
      idle();
      check("instret_wrap", inst_b, 0);
      check("instret_wrap_nb", inst_n, 0);

      // Reset wins over a simultaneous write.
      drive(1'b1, 5'd11, 2'd0, 32'h0000_00AB, 3'b010, 2'd0);
      step();
      rst = 1'b1;
      drive(1'b1, 5'd3, 2'd0, 32'hAAAA_5555, 3'b010, 2'd0);
      step();
      rst = 1'b0;
      idle();
      read(5'd3, 5'd11);
      check("rstw_x3", rdata_b[31:0], 0);
      check("rstw_x11", rdata_b[63:32], 0);
      check("rstw_instret", inst_b, 0);
      check("rstw_instret_nb", inst_n, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
